mdu_seq: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core. Sits in the E stage alongside the ALU and owns the HI/LO registers.
- Consumes the 4-bit MDU opcode and start strobe produced by the main decoder.
- Extends the existing op set with configurable latencies, multiply-accumulate ops, a flush/cancel input and a divide-by-zero status flag.

---
 rtl/mdu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_mdu_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit with HI/LO ownership.
//
// The result is computed from the operands and the current HI/LO at the
// start edge. It is held in a shadow register while a down-counter runs
// for the configured latency. It is copied into HI/LO when the counter
// reaches terminal count, unless a flush arrives first.
//
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   req      - MDU instruction valid in E stage
//   mdu_op   - 4-bit MDU opcode from the main decoder
//   rs_val   - operand A / move-to source
//   rt_val   - operand B
//   flush    - cancel any in-flight operation and any same-cycle request
//   busy     - multi-cycle operation in progress
//   rdata    - combinational HI (mfhi) / LO (mflo) read port, else 0
//   hi, lo   - architectural HI/LO registers
//   dz       - sticky divide-by-zero status of the last div/divu
//
// state  | meaning
// S_IDLE | no operation in flight, accepts requests
// S_MUL  | mult-class result waiting out MULT_CYCLES
// S_DIV  | div-class result waiting out DIV_CYCLES
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;
  localparam logic [3:0] OP_MADD  = 4'b1001;
  localparam logic [3:0] OP_MADDU = 4'b1010;
  localparam logic [3:0] OP_MSUB  = 4'b1011;
  localparam logic [3:0] OP_MSUBU = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic               busy_q, busy_d;
  logic               dz_q, dz_d;
  logic               wr_en_q, wr_en_d;
  logic               dz_set_q, dz_set_d;

  // ---------------- multiply / multiply-accumulate ----------------
  logic                 mul_signed;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod, hilo_cur, mac;

  assign mul_signed = (mdu_op == OP_MULT) || (mdu_op == OP_MADD) || (mdu_op == OP_MSUB);
  assign a_ext = mul_signed ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
  assign b_ext = mul_signed ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
  // Low 2*WIDTH bits of the extended product equal the signed product modulo 2^(2*WIDTH).
  assign prod     = a_ext * b_ext;
  assign hilo_cur = {hi_q, lo_q};

  always_comb begin
    mac = prod;
    case (mdu_op)
      OP_MADD, OP_MADDU: mac = hilo_cur + prod;
      OP_MSUB, OP_MSUBU: mac = hilo_cur - prod;
      default:           mac = prod;
    endcase
  end

  // ---------------- divide (sign-magnitude around an unsigned divider) ----------------
  logic               div_signed, a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;

  assign div_signed = (mdu_op == OP_DIV);
  assign a_neg      = div_signed & rs_val[WIDTH-1];
  assign b_neg      = div_signed & rt_val[WIDTH-1];
  assign mag_a      = a_neg ? -rs_val : rs_val;
  assign mag_b      = b_neg ? -rt_val : rt_val;
  assign div_zero   = (rt_val == '0);
  // Dummy divisor keeps the divider defined; the result is discarded on divide-by-zero.
  assign div_b      = div_zero ? WIDTH'(1) : mag_b;
  assign q_mag      = mag_a / div_b;
  assign r_mag      = mag_a % div_b;
  // INT_MIN / -1 falls out naturally: magnitude 2^(W-1) negates back to INT_MIN, remainder 0.
  assign quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem        = a_neg ? -r_mag : r_mag;

  // ---------------- control ----------------
  logic accept;
  assign accept = req & ~busy_q & ~flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    busy_d   = busy_q;
    dz_d     = dz_q;
    wr_en_d  = wr_en_q;
    dz_set_d = dz_set_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (mdu_op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              state_d  = S_MUL;
              busy_d   = 1'b1;
              cnt_d    = MUL_LOAD;
              res_hi_d = mac[2*WIDTH-1:WIDTH];
              res_lo_d = mac[WIDTH-1:0];
              wr_en_d  = 1'b1;
              dz_set_d = 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              state_d  = S_DIV;
              busy_d   = 1'b1;
              cnt_d    = DIV_LOAD;
              res_hi_d = rem;
              res_lo_d = quot;
              wr_en_d  = ~div_zero;
              dz_set_d = div_zero;
              if (!div_zero) dz_d = 1'b0;
            end
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      default: begin
        if (flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (wr_en_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
          if (dz_set_q) dz_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
      wr_en_q  <= 1'b0;
      dz_set_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      busy_q   <= busy_d;
      dz_q     <= dz_d;
      wr_en_q  <= wr_en_d;
      dz_set_q <= dz_set_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (mdu_op == OP_MFHI) rdata = hi_q;
    else if (mdu_op == OP_MFLO) rdata = lo_q;
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;
  localparam logic [3:0] OP_MADD  = 4'b1001;
  localparam logic [3:0] OP_MADDU = 4'b1010;
  localparam logic [3:0] OP_MSUB  = 4'b1011;
  localparam logic [3:0] OP_MSUBU = 4'b1100;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dz;

  int n_run;
  int n_fail;

  // Reference architectural state
  logic [31:0] hi_m, lo_m;
  logic        dz_m;

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .mdu_op(mdu_op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .busy(busy),
    .rdata(rdata), .hi(hi), .lo(lo), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, hl;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    hl = {hi_m, lo_m};
    case (op)
      OP_MULT:  hl = $unsigned(sa * sb);
      OP_MULTU: hl = ua * ub;
      OP_MADD:  hl = hl + $unsigned(sa * sb);
      OP_MADDU: hl = hl + ua * ub;
      OP_MSUB:  hl = hl - $unsigned(sa * sb);
      OP_MSUBU: hl = hl - ua * ub;
      default: ;
    endcase
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        hi_m = hl[63:32];
        lo_m = hl[31:0];
      end
      OP_DIV: begin
        if (b == 32'h0) dz_m = 1'b1;
        else begin
          sq = sa / sb;
          sr = sa % sb;
          lo_m = sq[31:0];
          hi_m = sr[31:0];
          dz_m = 1'b0;
        end
      end
      OP_DIVU: begin
        if (b == 32'h0) dz_m = 1'b1;
        else begin
          lo_m = a / b;
          hi_m = a % b;
          dz_m = 1'b0;
        end
      end
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      default: ;
    endcase
  endtask

  function automatic int exp_cycles(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 5;
      OP_DIV, OP_DIVU: return 10;
      default: return 0;
    endcase
  endfunction

  // Issues one request (caller sits on a falling edge) and counts busy cycles,
  // returning on the first falling edge where busy is low (bounded).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nb);
    req = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    @(negedge clk);
    req = 1'b0; mdu_op = OP_NOP;
    nb = 0;
    while (busy === 1'b1 && nb < 64) begin
      nb++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 1'b0; mdu_op = OP_MFHI; rs_val = '0; rt_val = '0; flush = 1'b0;
    #2;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_run++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_run++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_run++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", dz); end
    n_run++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    mdu_op = OP_NOP;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
  endtask

  task automatic test_mult();
    int nb;
    do_op(OP_MULT, 32'hFFFFFFFE, 32'h3, nb); model_op(OP_MULT, 32'hFFFFFFFE, 32'h3);
    n_run++; if (nb != 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 5", nb); end
    n_run++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_run++; if (lo !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
    do_op(OP_MULTU, 32'hFFFFFFFE, 32'h3, nb); model_op(OP_MULTU, 32'hFFFFFFFE, 32'h3);
    n_run++; if (nb != 5) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 5", nb); end
    n_run++; if (hi !== 32'h2) begin n_fail++; $display("FAIL multu_hi: got %h want 00000002", hi); end
    n_run++; if (lo !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffa", lo); end
    mdu_op = OP_MFHI; #1;
    n_run++; if (rdata !== 32'h2) begin n_fail++; $display("FAIL mfhi_rdata: got %h want 00000002", rdata); end
    mdu_op = OP_MFLO; #1;
    n_run++; if (rdata !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mflo_rdata: got %h want fffffffa", rdata); end
    mdu_op = OP_NOP;
    @(negedge clk);
  endtask

  task automatic test_div();
    int nb;
    do_op(OP_DIV, 32'hFFFFFFF9, 32'h2, nb); model_op(OP_DIV, 32'hFFFFFFF9, 32'h2);
    n_run++; if (nb != 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 10", nb); end
    n_run++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_run++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    n_run++; if (dz !== 1'b0) begin n_fail++; $display("FAIL div_dz: got %b want 0", dz); end
    do_op(OP_DIVU, 32'h7, 32'h0, nb); model_op(OP_DIVU, 32'h7, 32'h0);
    n_run++; if (nb != 10) begin n_fail++; $display("FAIL divz_busy_cycles: got %0d want 10", nb); end
    n_run++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL divz_lo: got %h want fffffffd", lo); end
    n_run++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_hi: got %h want ffffffff", hi); end
    n_run++; if (dz !== 1'b1) begin n_fail++; $display("FAIL divz_dz: got %b want 1", dz); end
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, nb); model_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    n_run++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
    n_run++; if (hi !== 32'h0) begin n_fail++; $display("FAIL divovf_hi: got %h want 00000000", hi); end
    n_run++; if (dz !== 1'b0) begin n_fail++; $display("FAIL divovf_dz: got %b want 0", dz); end
  endtask

  task automatic test_mac();
    int nb;
    do_op(OP_MTHI, 32'h1, 32'h0, nb); model_op(OP_MTHI, 32'h1, 32'h0);
    n_run++; if (nb != 0) begin n_fail++; $display("FAIL mthi_busy_cycles: got %0d want 0", nb); end
    n_run++; if (hi !== 32'h1) begin n_fail++; $display("FAIL mthi_hi: got %h want 00000001", hi); end
    do_op(OP_MTLO, 32'h0, 32'h0, nb); model_op(OP_MTLO, 32'h0, 32'h0);
    n_run++; if (lo !== 32'h0) begin n_fail++; $display("FAIL mtlo_lo: got %h want 00000000", lo); end
    do_op(OP_MADDU, 32'hFFFFFFFF, 32'h2, nb); model_op(OP_MADDU, 32'hFFFFFFFF, 32'h2);
    n_run++; if (nb != 5) begin n_fail++; $display("FAIL maddu_busy_cycles: got %0d want 5", nb); end
    n_run++; if (hi !== 32'h2) begin n_fail++; $display("FAIL maddu_hi: got %h want 00000002", hi); end
    n_run++; if (lo !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL maddu_lo: got %h want fffffffe", lo); end
    do_op(OP_MSUB, 32'h1, 32'h1, nb); model_op(OP_MSUB, 32'h1, 32'h1);
    n_run++; if (hi !== 32'h2) begin n_fail++; $display("FAIL msub_hi: got %h want 00000002", hi); end
    n_run++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL msub_lo: got %h want fffffffd", lo); end
  endtask

  task automatic test_flush();
    int nb;
    // Flush in the 4th busy cycle of a divide.
    req = 1'b1; mdu_op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    req = 1'b0; mdu_op = OP_NOP;
    repeat (3) @(negedge clk);
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    n_run++; if (hi !== hi_m) begin n_fail++; $display("FAIL flush_hi: got %h want %h", hi, hi_m); end
    n_run++; if (lo !== lo_m) begin n_fail++; $display("FAIL flush_lo: got %h want %h", lo, lo_m); end
    // New request right after the flush.
    do_op(OP_MULT, 32'd6, 32'd7, nb); model_op(OP_MULT, 32'd6, 32'd7);
    n_run++; if (nb != 5) begin n_fail++; $display("FAIL postflush_busy_cycles: got %0d want 5", nb); end
    n_run++; if (lo !== 32'd42 || hi !== 32'd0) begin n_fail++; $display("FAIL postflush_hilo: got %h_%h want 00000000_0000002a", hi, lo); end
    // Flush landing on the completion edge suppresses the commit.
    req = 1'b1; mdu_op = OP_MULT; rs_val = 32'd3; rt_val = 32'd3;
    @(negedge clk);
    req = 1'b0; mdu_op = OP_NOP;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lastflush_busy: got %b want 0", busy); end
    n_run++; if (lo !== lo_m || hi !== hi_m) begin n_fail++; $display("FAIL lastflush_hilo: got %h_%h want %h_%h", hi, lo, hi_m, lo_m); end
    @(negedge clk);
    n_run++; if (lo !== lo_m) begin n_fail++; $display("FAIL lastflush_late_lo: got %h want %h", lo, lo_m); end
  endtask

  task automatic test_reset_mid();
    int nb;
    do_op(OP_MTHI, 32'hABCD, 32'h0, nb); model_op(OP_MTHI, 32'hABCD, 32'h0);
    req = 1'b1; mdu_op = OP_MULT; rs_val = 32'd9; rt_val = 32'd9;
    @(negedge clk);
    req = 1'b0; mdu_op = OP_NOP;
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_run++; if (hi !== 32'h0) begin n_fail++; $display("FAIL midrst_hi: got %h want 0", hi); end
    n_run++; if (lo !== 32'h0) begin n_fail++; $display("FAIL midrst_lo: got %h want 0", lo); end
    @(negedge clk);
    reset_n = 1'b1;
    hi_m = '0; lo_m = '0; dz_m = 1'b0;
    repeat (6) @(negedge clk);
    n_run++; if (lo !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_lost: got lo=%h busy=%b want 0/0", lo, busy); end
  endtask

  task automatic test_collision();
    int nb;
    // Request together with flush is dropped.
    req = 1'b1; mdu_op = OP_MULT; rs_val = 32'd2; rt_val = 32'd2; flush = 1'b1;
    @(negedge clk);
    req = 1'b0; mdu_op = OP_NOP; flush = 1'b0;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reqflush_busy: got %b want 0", busy); end
    req = 1'b1; mdu_op = OP_MTLO; rs_val = 32'h55; flush = 1'b1;
    @(negedge clk);
    req = 1'b0; mdu_op = OP_NOP; flush = 1'b0;
    n_run++; if (lo !== lo_m) begin n_fail++; $display("FAIL reqflush_mtlo: got %h want %h", lo, lo_m); end
    // mtlo while busy is ignored.
    req = 1'b1; mdu_op = OP_MULT; rs_val = 32'd5; rt_val = 32'd5;
    @(negedge clk);
    mdu_op = OP_MTLO; rs_val = 32'h1234;
    @(negedge clk);
    req = 1'b0; mdu_op = OP_NOP;
    nb = 2;
    while (busy === 1'b1 && nb < 64) begin
      nb++;
      @(negedge clk);
    end
    model_op(OP_MULT, 32'd5, 32'd5);
    n_run++; if (nb != 6) begin n_fail++; $display("FAIL busymt_cycles: got %0d want 6", nb); end
    n_run++; if (lo !== lo_m) begin n_fail++; $display("FAIL busymt_lo: got %h want %h", lo, lo_m); end
  endtask

  task automatic test_back_to_back();
    int nb;
    do_op(OP_MULT, 32'h12345678, 32'h9ABCDEF0, nb); model_op(OP_MULT, 32'h12345678, 32'h9ABCDEF0);
    do_op(OP_MADD, 32'hFFFF0000, 32'h00010001, nb); model_op(OP_MADD, 32'hFFFF0000, 32'h00010001);
    n_run++; if (nb != 5) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 5", nb); end
    n_run++; if (hi !== hi_m || lo !== lo_m) begin n_fail++; $display("FAIL b2b_hilo: got %h_%h want %h_%h", hi, lo, hi_m, lo_m); end
  endtask

  task automatic test_random();
    logic [3:0]  ops [10];
    logic [3:0]  op;
    logic [31:0] a, b;
    int nb;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(9)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(3) == 0) b = 32'($urandom_range(16)) - 32'd8;
      if ((op == OP_DIV || op == OP_DIVU) && $urandom_range(3) == 0) b = 32'h0;
      if (op == OP_DIV && $urandom_range(7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      do_op(op, a, b, nb);
      model_op(op, a, b);
      n_run++; if (nb != exp_cycles(op)) begin n_fail++; $display("FAIL rnd_cycles[%0d] op=%h: got %0d want %0d", i, op, nb, exp_cycles(op)); end
      n_run++; if (hi !== hi_m || lo !== lo_m) begin n_fail++; $display("FAIL rnd_hilo[%0d] op=%h a=%h b=%h: got %h_%h want %h_%h", i, op, a, b, hi, lo, hi_m, lo_m); end
      n_run++; if (dz !== dz_m) begin n_fail++; $display("FAIL rnd_dz[%0d] op=%h: got %b want %b", i, op, dz, dz_m); end
      mdu_op = (i % 2 == 0) ? OP_MFHI : OP_MFLO;
      #1;
      n_run++; if (rdata !== ((i % 2 == 0) ? hi_m : lo_m)) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rdata, (i % 2 == 0) ? hi_m : lo_m); end
      mdu_op = OP_NOP;
      @(negedge clk);
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_mult();
    test_div();
    test_mac();
    test_flush();
    test_reset_mid();
    test_collision();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
